// File: rtl/ro25_axil_slave_regs.sv
// ro25_axil_slave_regs
// AXI4-Lite responder holding NUM_REGS read/write control registers for the
// RO_25 peripheral. The registers are also driven out in parallel to the
// ring-oscillator fabric.
//
// Ports:
//   ACLK, ARESETN                clock (rising edge) and async active-low reset
//   S_AXI_AW*                    write address channel (AWPROT ignored)
//   S_AXI_W*                     write data channel with byte strobes
//   S_AXI_B*                     write response channel (OKAY / SLVERR)
//   S_AXI_AR*                    read address channel (ARPROT ignored)
//   S_AXI_R*                     read data channel (OKAY / SLVERR)
//   REG_OUT                      register k at bits [32k+31:32k]
//
// AW and W are captured independently into holding registers. The write is
// committed on the first edge where both are held, which also raises BVALID.
// Each direction allows only one transaction in flight.
module ro25_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                 ACLK,
    input  logic                                 ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                           S_AXI_AWPROT,
    input  logic                                 S_AXI_AWVALID,
    output logic                                 S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                                 S_AXI_WVALID,
    output logic                                 S_AXI_WREADY,
    output logic [1:0]                           S_AXI_BRESP,
    output logic                                 S_AXI_BVALID,
    input  logic                                 S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                           S_AXI_ARPROT,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] REG_OUT
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word index addresses an implemented register
    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return (32'(idx) < 32'(NUM_REGS));
    endfunction

    logic              aw_held_q, aw_held_d;
    logic              w_held_q,  w_held_d;
    logic [IDX_W-1:0]  aw_idx_q,  aw_idx_d;
    logic [DW-1:0]     wdata_q,   wdata_d;
    logic [STRB_W-1:0] wstrb_q,   wstrb_d;
    logic              bvalid_q,  bvalid_d;
    logic [1:0]        bresp_q,   bresp_d;
    logic              rvalid_q,  rvalid_d;
    logic [1:0]        rresp_q,   rresp_d;
    logic [DW-1:0]     rdata_q,   rdata_d;
    logic              awready_q, awready_d;
    logic              wready_q,  wready_d;
    logic              arready_q, arready_d;
    logic [DW-1:0]     regs_q [NUM_REGS];
    logic [DW-1:0]     regs_d [NUM_REGS];

    logic             aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic [IDX_W-1:0] ar_idx_s;
    logic             unused_s;

    assign aw_hs_s  = S_AXI_AWVALID && awready_q;
    assign w_hs_s   = S_AXI_WVALID  && wready_q;
    assign ar_hs_s  = S_AXI_ARVALID && arready_q;
    assign commit_s = aw_held_q && w_held_q;
    assign ar_idx_s = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Next-state for write capture/commit, read response and ready flags
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
        end

        if (commit_s) begin
            // Readies are low while both are held, so no new capture can collide
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (idx_in_range(aw_idx_q)) begin
                bresp_d = RESP_OKAY;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (32'(aw_idx_q) == 32'(k)) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wstrb_q[b]) begin
                                regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                            end else begin
                                regs_d[k][8*b +: 8] = regs_q[k][8*b +: 8];
                            end
                        end
                    end else begin
                        regs_d[k] = regs_q[k];
                    end
                end
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end else begin
            if (aw_hs_s) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end else begin
                aw_held_d = aw_held_q;
            end
            if (w_hs_s) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end else begin
                w_held_d = w_held_q;
            end
            if (bvalid_q && S_AXI_BREADY) begin
                bvalid_d = 1'b0;
            end else begin
                bvalid_d = bvalid_q;
            end
        end

        // Reads sample regs_q, so a read on the commit edge sees the old value
        if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = {DW{1'b0}};
            if (idx_in_range(ar_idx_s)) begin
                rresp_d = RESP_OKAY;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (32'(ar_idx_s) == 32'(k)) begin
                        rdata_d = regs_q[k];
                    end else begin
                        rdata_d = rdata_d;
                    end
                end
            end else begin
                rresp_d = RESP_SLVERR;
            end
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end

        // Readies are registered images of the next-state flags, so they
        // stay low in reset and rise on the first edge after release
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d  && !bvalid_d;
        arready_d = !rvalid_d;
    end

    // State, response and register-file flops
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= {IDX_W{1'b0}};
            wdata_q   <= {DW{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= {DW{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= {DW{1'b0}};
            end
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign REG_OUT[DW*g +: DW] = regs_q[g];
    end

endmodule
